// File: rtl/parity_rx_pkg.sv
// Shared definitions for the parity_rx serial receiver:
// FSM state encodings and frame-length helpers.
package parity_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    // Start, parity and stop bits surround the data bits.
    localparam int FRAME_OVERHEAD = 3;

    function automatic int frame_len(input int data_bits);
        return data_bits + FRAME_OVERHEAD;
    endfunction

endpackage

// File: rtl/parity_rx_acc.sv
// Enable-gated, clearable 1-bit XOR accumulator (running parity).
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 1'b0;
        end else if (en_i) begin
            q_d = q_q ^ d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver: start, DATA_BITS data (LSB first), parity, stop.
// Samples rxd only on bit_en strobes; reports each frame with a valid pulse.
module parity_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 par_err,
    output logic                 frm_err,
    output logic                 busy
);

    localparam int            CW   = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
    localparam logic          ODD  = (PARITY_ODD != 0);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic                   busy_q, busy_d;
    logic                   perr_q, perr_d;
    logic                   acc_clr;
    logic                   acc_en;
    logic                   xor_q;

    parity_acc u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .d_i   (rxd),
        .q_o   (xor_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        busy_d    = busy_q;
        perr_d    = perr_q;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bit_en && !rxd) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                    busy_d  = 1'b1;
                    perr_d  = 1'b0;
                end
            end
            DATA: begin
                if (bit_en) begin
                    // LSB arrives first, so bits enter at the top
                    shift_d              = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rxd;
                    acc_en               = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_en) begin
                    perr_d  = ((xor_q ^ rxd) != ODD);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_en) begin
                    state_d   = IDLE;
                    valid_d   = 1'b1;
                    data_d    = shift_q;
                    par_err_d = perr_q;
                    frm_err_d = ~rxd;
                    busy_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            busy_q    <= busy_d;
            perr_q    <= perr_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign par_err = par_err_q;
    assign frm_err = frm_err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: even and odd parity instances
// share one serial line; a scoreboard checks every valid pulse.
module tb_parity_rx;
    import parity_rx_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en = 1'b0;
    logic       rxd = 1'b1;

    logic [7:0] data_e, data_o;
    logic       valid_e, valid_o;
    logic       perr_e, perr_o;
    logic       ferr_e, ferr_o;
    logic       busy_e, busy_o;

    exp_t       exp_e[$];
    exp_t       exp_o[$];
    int         vt[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic       prev_v = 1'b0;

    parity_rx #(.DATA_BITS(8), .PARITY_ODD(0)) dut_e (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en),
        .rxd     (rxd),
        .data    (data_e),
        .valid   (valid_e),
        .par_err (perr_e),
        .frm_err (ferr_e),
        .busy    (busy_e)
    );

    parity_rx #(.DATA_BITS(8), .PARITY_ODD(1)) dut_o (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en),
        .rxd     (rxd),
        .data    (data_o),
        .valid   (valid_o),
        .par_err (perr_o),
        .frm_err (ferr_o),
        .busy    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] d,
                            input logic pe, input logic fe,
                            inout exp_t q[$]);
        exp_t x;
        checks++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL %s_unexpected_valid: got data %0h", tag, d);
        end
        if (q.size() != 0) begin
            x = q.pop_front();
            checks++;
            assert ({d, pe, fe} === x) else begin
                errors++;
                $error("FAIL %s_frame: got d=%0h pe=%0b fe=%0b expected d=%0h pe=%0b fe=%0b",
                       tag, d, pe, fe, x.d, x.pe, x.fe);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (valid_e) begin
            vt.push_back(cyc);
            sb_check("even", data_e, perr_e, ferr_e, exp_e);
            checks++;
            assert (!prev_v) else begin
                errors++;
                $error("FAIL valid_width: got 2+ cycles expected 1");
            end
        end
        if (valid_o) begin
            sb_check("odd", data_o, perr_o, ferr_o, exp_o);
        end
        prev_v = valid_e;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap, input bit gl);
        rxd    = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        for (int i = 1; i < gap; i++) begin
            if (gl) rxd = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stp, input int gap,
                              input bit gl);
        exp_e.push_back('{d, ((^d) ^ par) != 1'b0, ~stp});
        exp_o.push_back('{d, ((^d) ^ par) != 1'b1, ~stp});
        send_bit(1'b0, gap, gl);
        chk("busy_set", busy_e, 1);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap, gl);
        send_bit(par, gap, gl);
        rxd    = stp;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        chk("valid_after_stop", valid_e, 1);
        chk("busy_drop", busy_e, 0);
        for (int i = 1; i < gap; i++) begin
            if (gl) rxd = 1'($urandom_range(0, 1));
            tick();
            if (i == 1) chk("valid_fall", valid_e, 0);
        end
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        rxd    = 1'b1;
        bit_en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_valid", valid_e, 0);
        chk("rst_busy", busy_e, 0);
        chk("rst_data", data_e, 0);
        chk("rst_flags", {perr_e, ferr_e, perr_o, ferr_o}, 0);
        rst = 1'b0;

        // Strobes with rxd=1 in IDLE must not start a frame
        rxd    = 1'b1;
        bit_en = 1'b1;
        repeat (3) tick();
        bit_en = 1'b0;
        chk("idle_hold", busy_e, 0);

        send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0);
        idle(2);
        send_frame(8'h01, 1'b0, 1'b1, 1, 1'b0);
        idle(2);
        send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1, 1'b0);
        idle(2);
        send_frame(8'hFF, 1'b0, 1'b1, 4, 1'b1);
        idle(2);
        chk("ff_data_hold", data_e, 8'hFF);

        // Abandon a frame with reset after its 4th data bit
        send_bit(1'b0, 1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", valid_e, 0);
        chk("abort_busy", busy_e, 0);
        chk("abort_data", data_e, 0);
        chk("abort_flags", {perr_e, ferr_e}, 0);
        idle(14);
        chk("abort_no_frame", busy_e, 0);

        send_frame(8'h81, 1'b0, 1'b1, 1, 1'b0);
        idle(3);
        vt.delete();
        send_frame(8'h12, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b1, 1, 1'b0);
        idle(3);
        chk("b2b_count", vt.size(), 2);
        if (vt.size() == 2)
            chk("b2b_space", vt[1] - vt[0], frame_len(8));
        chk("b2b_last", data_e, 8'h34);
        chk("sb_even_drained", exp_e.size(), 0);
        chk("sb_odd_drained", exp_o.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_rx.md
PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame, legal range 1..16.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port bit_en, input, 1: bit-time strobe; rxd is sampled only in cycles where bit_en=1.
REQ-006 Port rxd, input, 1: serial line; idle level 1.
REQ-007 Port data, output, DATA_BITS: received word, LSB first on the line.
REQ-008 Port valid, output, 1: one-cycle pulse marking that data, par_err and frm_err are new.
REQ-009 Port par_err, output, 1: parity mismatch flag for the frame marked by valid.
REQ-010 Port frm_err, output, 1: stop-bit-was-0 flag for the frame marked by valid.
REQ-011 Port busy, output, 1: high from start-bit detection until the stop bit is sampled.

Function
REQ-012 Frame on rxd SHALL be: start(0), DATA_BITS data bits LSB first, parity bit, stop(1); one bit per bit_en strobe.
REQ-013 The state machine SHALL have four states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE SHALL move to DATA when bit_en=1 and rxd=0, clear the bit counter and set busy.
REQ-015 In IDLE, rxd=1 or bit_en=0 SHALL hold the state.
REQ-016 DATA SHALL shift rxd into the data shift register on each bit_en and fold it into a running XOR.
REQ-017 DATA SHALL move to PARITY on the strobe that samples bit DATA_BITS-1; the counter SHALL be clog2(DATA_BITS+1) bits and never wrap.
REQ-018 PARITY SHALL sample rxd on bit_en and latch a mismatch when (running XOR ^ rxd) != PARITY_ODD.
REQ-019 STOP SHALL sample rxd on bit_en, set frm_err = ~rxd, and return to IDLE in the same cycle.
REQ-020 valid SHALL be 1 for exactly one clk cycle: the cycle after the edge on which the stop bit is sampled.
REQ-021 data, par_err and frm_err SHALL update on that same edge and hold until the next valid.
REQ-022 A frame with errors SHALL still assert valid, with the flags set.
REQ-023 busy SHALL drop on the edge on which the stop bit is sampled.
REQ-024 When bit_en=0, no state, counter, shift register or XOR SHALL change; gaps of any length between strobes are legal.
REQ-025 bit_en held at 1 every cycle SHALL be legal; the frame then takes DATA_BITS+3 cycles.
REQ-026 The start bit SHALL be sampled on the first strobe: a 0 sampled in IDLE on a strobe is a start bit, with no mid-bit re-check.
REQ-027 rxd=0 sampled in STOP SHALL flag frm_err and return to IDLE; the next strobe with rxd=0 starts a new frame.
REQ-028 A new frame SHALL be accepted on the strobe after the stop strobe, giving back-to-back frames with no idle bit.

Reset
REQ-029 rst=1 on a clock edge SHALL force IDLE and set data=0, valid=0, par_err=0, frm_err=0, busy=0, and clear the counter and XOR.
REQ-030 rst SHALL take priority over bit_en.
REQ-031 rst during a frame SHALL abandon that frame with no valid pulse.
REQ-032 After reset release, the block SHALL wait in IDLE for a start bit.

Structure
REQ-033 The state encodings (IDLE=0, DATA=1, PARITY=2, STOP=3) and the frame-length constant SHALL live in shared package parity_rx_pkg.
REQ-034 The block SHALL use one sub-module, parity_acc: an enable-gated, clearable, 1-bit XOR accumulator used for the running parity.
REQ-035 All outputs SHALL be driven from registers.

Verification
REQ-036 bit_en=1 every cycle; send 0xA5, parity 0, stop 1 -> one valid pulse, data=0xA5, par_err=0, frm_err=0.
REQ-037 Send 0x01, parity 0 (wrong for even) -> valid, data=0x01, par_err=1, frm_err=0; repeat with PARITY_ODD=1 -> par_err=0.
REQ-038 Send 0x3C, parity 0, stop 0 -> valid, data=0x3C, frm_err=1, par_err=0; the following frame 0x55 is received cleanly.
REQ-039 bit_en every 4th cycle, random rxd glitches between strobes; send 0xFF, parity 0 -> data=0xFF, no errors, and valid falls exactly one cycle after the stop strobe.
REQ-040 Assert rst for 1 cycle after the 4th data bit -> no valid pulse, outputs zero, busy=0; the next frame 0x81 is received correctly.
REQ-041 Send 0x12 and 0x34 back-to-back with no idle bit -> two valid pulses spaced DATA_BITS+3 strobes apart, with data 0x12 then 0x34.
